// File: rtl/hram_cmd_pkg.sv
// hram_cmd_pkg: shared constants and state types for the
// serial command engine (command codes, reply words, FSM states).
package hram_cmd_pkg;

  localparam logic [7:0] CMD_ADDR     = 8'h01;
  localparam logic [7:0] CMD_LOAD     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_READ     = 8'h04;
  localparam logic [7:0] CMD_READ_REQ = 8'h05;
  localparam logic [7:0] CMD_COUNT    = 8'h06;
  localparam logic [7:0] CMD_CONST    = 8'h07;
  localparam logic [7:0] CMD_SPACE    = 8'h08;
  localparam logic [7:0] CMD_STATUS   = 8'h09;

  localparam logic [31:0] CONST_WORD = 32'h0000_0103;
  localparam logic [31:0] ERR_PREFIX = 32'hEEEE_EE00;
  localparam logic [31:0] TMO_PREFIX = 32'hDEAD_0000;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_EXEC,
    S_MEM_ISSUE,
    S_MEM_WAIT,
    S_TX_LOAD,
    S_TX_BUSY
  } eng_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_LOW,
    TX_WAIT_HIGH
  } tx_state_t;

  function automatic logic is_mem_cmd(input logic [7:0] c);
    return (c == CMD_WRITE) || (c == CMD_READ_REQ);
  endfunction

endpackage

// File: rtl/hram_reply_tx.sv
// hram_reply_tx: sends a 32-bit reply as 4 bytes, MSB first,
// over the UART tx handshake.
// Ports: clk, reset; load/word take a reply; tx_ready in;
// tx_data/tx_start to the UART; done pulses after the 4th byte.
module hram_reply_tx
  import hram_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        done
);

  tx_state_t   state, state_nx;
  logic [31:0] sh;
  logic [1:0]  cnt;

  // Byte on the wire is always the top of the shifter, so it is
  // stable from TX_START until the shift after TX_WAIT_HIGH.
  assign tx_data = sh[31:24];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= TX_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    done     = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (load) state_nx = TX_START;
      end
      TX_START: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          state_nx = TX_WAIT_LOW;
        end
      end
      TX_WAIT_LOW: begin
        if (!tx_ready) state_nx = TX_WAIT_HIGH;
      end
      TX_WAIT_HIGH: begin
        if (tx_ready) begin
          if (cnt == 2'd3) begin
            done     = 1'b1;
            state_nx = TX_IDLE;
          end else begin
            state_nx = TX_START;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (state == TX_IDLE && load) begin
      sh  <= word;
      cnt <= '0;
    end else if (state == TX_WAIT_HIGH && tx_ready) begin
      sh  <= {sh[23:0], 8'h00};
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/hram_cmd_engine.sv
// hram_cmd_engine: frames 5-byte UART commands, drives the
// HyperRAM controller strobes and returns a 4-byte reply.
// Ports: clk, reset; rx_data/rx_valid in; tx_data/tx_start/tx_ready
// to the UART; addr/wr_d/wr_req/rd_req/mem_or_reg and
// rd_d/rd_rdy/busy to the controller.
module hram_cmd_engine
  import hram_cmd_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT = 960000,
  parameter int unsigned MEM_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic [31:0] addr,
  output logic [31:0] wr_d,
  output logic        wr_req,
  output logic        rd_req,
  output logic        mem_or_reg,
  input  logic [31:0] rd_d,
  input  logic        rd_rdy,
  input  logic        busy
);

  localparam logic [31:0] FT_LIM = 32'(FRAME_TIMEOUT - 1);
  localparam logic [31:0] MT_LIM = 32'(MEM_TIMEOUT - 1);

  eng_state_t  state, state_nx;
  logic [39:0] frame;
  logic [2:0]  nbytes;
  logic [7:0]  cmd_q;
  logic [31:0] reply;
  logic [31:0] count;
  logic [31:0] rd_latch;
  logic [31:0] rd_tmp;
  logic [31:0] ft_cnt;
  logic [31:0] mt_cnt;
  logic        f_ovr, f_mem, f_frm;
  logic        b_seen, r_seen;
  logic        tx_load, tx_done;

  logic [7:0]  op_cmd;
  logic [31:0] opnd;
  logic        rx_take, frame_last, f_expire;
  logic        tmo_hit, mem_ok;

  assign op_cmd     = frame[39:32];
  assign opnd       = frame[31:0];
  assign rx_take    = rx_valid && (state == S_COLLECT);
  assign frame_last = rx_take && (nbytes == 3'd4);
  // A byte in the expiry cycle wins over the timeout.
  assign f_expire   = (state == S_COLLECT) && (nbytes != 3'd0)
                   && !rx_valid && (ft_cnt >= FT_LIM);
  assign tmo_hit    = mt_cnt >= MT_LIM;
  // rd_rdy landing with busy falling counts in the same cycle.
  assign mem_ok     = b_seen && !busy
                   && (cmd_q != CMD_READ_REQ || r_seen || rd_rdy);

  hram_reply_tx u_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_load),
    .word     (reply),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (tx_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_COLLECT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    tx_load  = 1'b0;
    unique case (state)
      S_COLLECT: begin
        if (frame_last) state_nx = S_EXEC;
      end
      S_EXEC: begin
        state_nx = is_mem_cmd(op_cmd) ? S_MEM_ISSUE : S_TX_LOAD;
      end
      S_MEM_ISSUE: begin
        if (tmo_hit) begin
          state_nx = S_TX_LOAD;
        end else if (!busy) begin
          wr_req   = (cmd_q == CMD_WRITE);
          rd_req   = (cmd_q == CMD_READ_REQ);
          state_nx = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ok || tmo_hit) state_nx = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        tx_load  = 1'b1;
        state_nx = S_TX_BUSY;
      end
      S_TX_BUSY: begin
        if (tx_done) state_nx = S_COLLECT;
      end
      default: state_nx = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame      <= '0;
      nbytes     <= '0;
      cmd_q      <= '0;
      reply      <= '0;
      count      <= '0;
      rd_latch   <= '0;
      rd_tmp     <= '0;
      ft_cnt     <= '0;
      mt_cnt     <= '0;
      f_ovr      <= 1'b0;
      f_mem      <= 1'b0;
      f_frm      <= 1'b0;
      b_seen     <= 1'b0;
      r_seen     <= 1'b0;
      addr       <= '0;
      wr_d       <= '0;
      mem_or_reg <= 1'b0;
    end else begin
      if (rx_valid) begin
        ft_cnt <= '0;
      end else if (ft_cnt != '1) begin
        ft_cnt <= ft_cnt + 32'd1;
      end

      unique case (state)
        S_COLLECT: begin
          if (rx_take) begin
            frame  <= {frame[31:0], rx_data};
            nbytes <= frame_last ? 3'd0 : nbytes + 3'd1;
          end else if (f_expire) begin
            nbytes <= '0;
            f_frm  <= 1'b1;
          end
        end
        S_EXEC: begin
          cmd_q  <= op_cmd;
          mt_cnt <= '0;
          unique case (1'b1)
            op_cmd == CMD_ADDR: begin
              addr  <= opnd;
              reply <= opnd;
            end
            op_cmd == CMD_LOAD: begin
              wr_d  <= opnd;
              reply <= opnd;
            end
            op_cmd == CMD_READ:  reply <= rd_latch;
            op_cmd == CMD_CONST: reply <= CONST_WORD;
            op_cmd == CMD_COUNT: begin
              reply <= count;
              count <= count + 32'd1;
            end
            op_cmd == CMD_SPACE: begin
              mem_or_reg <= opnd[0];
              reply      <= opnd;
            end
            op_cmd == CMD_STATUS: begin
              reply <= {29'b0, f_ovr, f_mem, f_frm};
              f_ovr <= 1'b0;
              f_mem <= 1'b0;
              f_frm <= 1'b0;
            end
            default: reply <= ERR_PREFIX | {24'h0, op_cmd};
          endcase
        end
        S_MEM_ISSUE: begin
          mt_cnt <= mt_cnt + 32'd1;
          if (tmo_hit) begin
            f_mem <= 1'b1;
            reply <= TMO_PREFIX | {24'h0, cmd_q};
          end else if (!busy) begin
            b_seen <= 1'b0;
            r_seen <= 1'b0;
          end
        end
        S_MEM_WAIT: begin
          mt_cnt <= mt_cnt + 32'd1;
          b_seen <= b_seen | busy;
          if (rd_rdy) begin
            r_seen <= 1'b1;
            rd_tmp <= rd_d;
          end
          // Read data is only committed on a completed read,
          // so a timed-out read leaves the latch untouched.
          if (mem_ok) begin
            if (cmd_q == CMD_READ_REQ) begin
              rd_latch <= rd_rdy ? rd_d : rd_tmp;
            end
            reply <= {24'h0, cmd_q};
          end else if (tmo_hit) begin
            f_mem <= 1'b1;
            reply <= TMO_PREFIX | {24'h0, cmd_q};
          end
        end
        default: ;
      endcase

      // Placed last so a byte dropped during STATUS still sticks.
      if (rx_valid && state != S_COLLECT) f_ovr <= 1'b1;
    end
  end

endmodule
